// File: rtl/fpu_collect_pkg.sv
// fpu_collect_pkg: tags, FSM states and drop-counter width for the FPU result collector
package fpu_collect_pkg;
  localparam logic [1:0] TAG_ADD = 2'b01;
  localparam logic [1:0] TAG_MUL = 2'b10;
  localparam logic [1:0] TAG_SUB = 2'b11;
  localparam int DROP_W = 8;
  typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;
endpackage

// File: rtl/fpu_res_fifo.sv
// fpu_res_fifo: W-wide, DEPTH-deep FIFO; a push while full is taken when a pop shares the cycle
module fpu_res_fifo #(
  parameter int W = 34,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp, rp;
  logic [W-1:0] mem [DEPTH];
  logic do_push, do_pop;
  always_comb begin
    full = wp[AW] != rp[AW] && wp[AW-1:0] == rp[AW-1:0];
    empty = wp == rp;
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    dout = empty ? '0 : mem[rp[AW-1:0]];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/fpu_result_collector.sv
// fpu_result_collector: tags and buffers FPU unit results, drains over valid/ready, flags frame end
// FPU_COLLECT_ERR_EN enables the sticky drop flag and the saturating drop counter.
module fpu_result_collector
  import fpu_collect_pkg::*;
#(
  parameter int DW = 32,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              add_vld,
  input  logic              mul_vld,
  input  logic              sub_vld,
  input  logic              fi,
  input  logic [DW-1:0]     add_res,
  input  logic [DW-1:0]     mul_res,
  input  logic [DW-1:0]     sub_res,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DW-1:0]     out_data,
  output logic [1:0]        out_tag,
  output logic              busy,
  output logic              frame_done,
  output logic              err,
  output logic [DROP_W-1:0] drop_cnt
);
  state_t state, state_d;
  logic full, empty, push, push_acc, pop;
  logic [1:0] tag;
  logic [DW-1:0] data;
  logic [DW+1:0] head;
  always_comb begin
    tag = add_vld ? TAG_ADD : mul_vld ? TAG_MUL : TAG_SUB;
    data = add_vld ? add_res : mul_vld ? mul_res : sub_res;
    push = state == COLLECT && (add_vld || mul_vld || sub_vld);
    out_valid = !empty;
    pop = out_valid && out_ready;
    push_acc = push && (!full || pop);
    state_d = (state == IDLE && en) ? COLLECT :
              (state == COLLECT && fi) ? DRAIN :
              (state == DRAIN && empty && !push) ? DONE :
              (state == DONE) ? IDLE : state;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else state <= state_d;
  end
  assign {out_tag, out_data} = head;
  assign busy = state != IDLE;
  assign frame_done = state == DONE;
  fpu_res_fifo #(.W(DW + 2), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push_acc), .pop(pop), .din({tag, data}),
    .dout(head), .full(full), .empty(empty)
  );
`ifdef FPU_COLLECT_ERR_EN
  logic [1:0] nv, ndrop;
  logic [DROP_W:0] sum;
  // Losers of arbitration and a rejected winner both count; anything outside IDLE/COLLECT drops.
  always_comb begin
    nv = 2'(add_vld) + 2'(mul_vld) + 2'(sub_vld);
    ndrop = state == COLLECT ? nv - 2'(push_acc) :
            (state == DRAIN || state == DONE) ? nv : 2'd0;
    sum = (DROP_W + 1)'(drop_cnt) + (DROP_W + 1)'(ndrop);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
      drop_cnt <= '0;
    end else begin
      err <= err | (ndrop != 2'd0);
      drop_cnt <= sum[DROP_W] ? '1 : sum[DROP_W-1:0];
    end
  end
`else
  assign err = 1'b0;
  assign drop_cnt = '0;
`endif
endmodule

// File: doc/fpu_result_collector.md
# fpu_result_collector

Downstream of the FPU timing controller: captures the 32-bit results of the add, multiply and subtract units on their one-cycle valid pulses. Each result is tagged with its operation and buffered in a small FIFO. Results drain to the consumer over a valid/ready interface. The block signals frame completion once the controller's `fi` pulse has been seen and every captured result has left the FIFO.

## Interface
- `DW`, 32, result data width
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `en`  in  1  frame enable, same signal that drives the timing controller
- `add_vld`  in  1  add result valid pulse
- `mul_vld`  in  1  mul result valid pulse
- `sub_vld`  in  1  sub result valid pulse
- `fi`  in  1  frame-final pulse from the timing controller
- `add_res`  in  DW  add unit result
- `mul_res`  in  DW  mul unit result
- `sub_res`  in  DW  sub unit result
- `out_valid`  out  1  FIFO head valid
- `out_ready`  in  1  consumer accepts head
- `out_data`  out  DW  head result
- `out_tag`  out  2  head op: 01 add, 10 mul, 11 sub
- `busy`  out  1  state ≠ IDLE
- `frame_done`  out  1  one-cycle pulse at end of frame
- `err`  out  1  sticky drop flag (macro only, else 0)
- `drop_cnt`  out  8  dropped-result count (macro only, else 0)

## Operation
- States:
  - IDLE: `en`=1 → COLLECT.
  - COLLECT: `fi`=1 → DRAIN.
  - DRAIN: FIFO empty, with no push in that cycle → DONE.
  - DONE: asserts `frame_done` → IDLE, unconditionally.
- Capture happens only in COLLECT, including the cycle in which `fi` arrives; `sub_vld` coincides with `fi`, so that capture must be taken.
- Valid pulses arriving in IDLE are ignored.
- Valid pulses arriving in DRAIN or DONE are drops.
- Simultaneous valids: priority add > mul > sub. The winner is pushed; each loser is a drop.
- Push when full:
  - with a same-cycle pop: accepted, occupancy unchanged;
  - otherwise: a drop, and the FIFO is unchanged.
- Pop happens when `out_valid` && `out_ready`.
- Pointers are log2(DEPTH) bits plus one wrap bit.
  - Full = index bits equal and wrap bits differ.
  - Empty = pointers equal.
  - Pointers wrap modulo 2·DEPTH.
- `out_data` and `out_tag` are driven from the head entry. Their value is don't-care while `out_valid`=0.
- `en` deasserting mid-frame does not abort the frame; only `rst` does.
- `rst` mid-operation: FIFO flushed, state IDLE, all outputs return to reset values.

## Timing
- Reset values:
  - `out_valid`, `busy`, `frame_done`, `err` = 0.
  - `drop_cnt` = 0.
  - `out_data` = 0, `out_tag` = 0, state IDLE.
- Latency: a push at edge N gives `out_valid`=1 after edge N; visible in cycle N+1.
- `busy` rises the cycle after `en` is sampled in IDLE.
- `frame_done` fires at the earliest two cycles after the last pop: one cycle in DRAIN seeing empty, then DONE.
- Once `out_valid` is high, `out_data` and `out_tag` stay stable until popped.

## Configuration
- `FPU_COLLECT_ERR_EN` defined:
  - each drop sets `err` (cleared only by `rst`);
  - each drop increments `drop_cnt`, saturating at 255;
  - two drops in one cycle add 2.
- `FPU_COLLECT_ERR_EN` undefined:
  - drops are silently discarded;
  - `err` and `drop_cnt` are tied to 0;
  - no counter logic is synthesised.

## Structure
- Package `fpu_collect_pkg`:
  - tag constants `TAG_ADD` = 2'b01, `TAG_MUL` = 2'b10, `TAG_SUB` = 2'b11;
  - state encoding (IDLE/COLLECT/DRAIN/DONE);
  - drop-counter width constant (8).
- Sub-module `fpu_res_fifo`: parameterised DW+2 wide, DEPTH deep.
  - Push/pop/full/empty, with push-when-full-plus-pop support.
  - The top level owns the FSM, the priority arbitration and the error logic.

## Test plan
- Nominal frame: `en`=1; `add_vld`@13 with 0x3F800000, `mul_vld`@23 with 0x40000000, `sub_vld`+`fi`@36 with 0xBF800000; `out_ready`=1 → three pops in order, tags 01/10/11, then `frame_done` pulse; `err`=0.
- Backpressure: `out_ready`=0 through the frame → `out_valid` held with head 0x3F800000/tag 01; release → drains in order; `frame_done` fires only after the third pop.
- Overflow (DEPTH=4, macro on): six valid pulses in COLLECT, `out_ready`=0 → four stored, `drop_cnt`=2, `err`=1.
- Collision: `add_vld` and `mul_vld` in the same cycle → only the add result is stored; macro on → `drop_cnt`+1.
- Full push+pop: FIFO full, `out_ready`=1, `sub_vld` same cycle → occupancy stays 4, no drop.
- Reset mid-DRAIN with two entries → `out_valid`=0, `busy`=0, `drop_cnt`=0 immediately; next frame behaves nominally.
